// File: rtl/hpdcache_core_req_buf_pkg.sv
// Shared types and limits for the per-requester core request buffer.
// The PMA attribute type is the one the rest of the HPDcache slice uses.
package hpdcache_core_req_buf_pkg;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    localparam int unsigned HPDCACHE_REQ_BUF_MIN_DEPTH = 2;
    localparam int unsigned HPDCACHE_REQ_BUF_MAX_DEPTH = 8;

endpackage

// File: rtl/hpdcache_core_req_buf.sv
// Request buffer between one core requester and the HPDcache crossbar.
// Ready/valid come from registered state only; second-cycle fields follow each side's handshake.
module hpdcache_core_req_buf
    import hpdcache_core_req_buf_pkg::*;
#(
    parameter type         hpdcache_req_t = logic,
    parameter type         hpdcache_tag_t = logic,
    parameter int unsigned DEPTH          = 2
)(
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          core_req_valid_i,
    output logic          core_req_ready_o,
    input  hpdcache_req_t core_req_i,
    input  logic          core_req_abort_i,
    input  hpdcache_tag_t core_req_tag_i,
    input  hpdcache_pma_t core_req_pma_i,

    output logic          xbar_req_valid_o,
    input  logic          xbar_req_ready_i,
    output hpdcache_req_t xbar_req_o,
    output logic          xbar_req_abort_o,
    output hpdcache_tag_t xbar_req_tag_o,
    output hpdcache_pma_t xbar_req_pma_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    typedef struct packed {
        hpdcache_req_t req;
        logic          abort;
        hpdcache_tag_t tag;
        hpdcache_pma_t pma;
        logic          snd_vld;
    } entry_t;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    entry_t        entries_q [DEPTH];
    entry_t        entries_d [DEPTH];
    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    cnt_t          count_q, count_d;
    logic          pend_vld_q, pend_vld_d;
    ptr_t          pend_idx_q, pend_idx_d;
    logic          out_abort_q, out_abort_d;
    hpdcache_tag_t out_tag_q, out_tag_d;
    hpdcache_pma_t out_pma_q, out_pma_d;

    entry_t        head;
    logic          push;
    logic          pop;

    assign head             = entries_q[rd_ptr_q];
    assign core_req_ready_o = (count_q != FULL_CNT);
    assign xbar_req_valid_o = (count_q != '0);
    assign push             = core_req_valid_i & core_req_ready_o;
    assign pop              = xbar_req_valid_o & xbar_req_ready_i;

    assign xbar_req_o       = head.req;
    assign xbar_req_abort_o = out_abort_q;
    assign xbar_req_tag_o   = out_tag_q;
    assign xbar_req_pma_o   = out_pma_q;

    always_comb begin
        entries_d   = entries_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_abort_d = out_abort_q;
        out_tag_d   = out_tag_q;
        out_pma_d   = out_pma_q;

        if (pend_vld_q) begin
            entries_d[pend_idx_q].abort   = core_req_abort_i;
            entries_d[pend_idx_q].tag     = core_req_tag_i;
            entries_d[pend_idx_q].pma     = core_req_pma_i;
            entries_d[pend_idx_q].snd_vld = 1'b1;
        end

        // The write slot is free whenever push is allowed, so it never aliases pend_idx_q.
        if (push) begin
            entries_d[wr_ptr_q].req     = core_req_i;
            entries_d[wr_ptr_q].snd_vld = 1'b0;
            wr_ptr_d                    = ptr_next(wr_ptr_q);
        end

        pend_vld_d = push;
        pend_idx_d = push ? wr_ptr_q : pend_idx_q;

        // A head whose second cycle is happening right now is served from the live core inputs.
        if (pop) begin
            if (head.snd_vld) begin
                out_abort_d = head.abort;
                out_tag_d   = head.tag;
                out_pma_d   = head.pma;
            end else begin
                out_abort_d = core_req_abort_i;
                out_tag_d   = core_req_tag_i;
                out_pma_d   = core_req_pma_i;
            end
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i].snd_vld <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            out_abort_q <= 1'b0;
            out_tag_q   <= '0;
            out_pma_q   <= '0;
        end else begin
            entries_q   <= entries_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            out_abort_q <= out_abort_d;
            out_tag_q   <= out_tag_d;
            out_pma_q   <= out_pma_d;
        end
    end

    logic [31:0] pend_off;
    logic        pend_occupied;

    always_comb begin
        pend_off      = (32'(pend_idx_q) + DEPTH - 32'(rd_ptr_q)) % DEPTH;
        pend_occupied = (pend_off < 32'(count_q));
    end

    a_depth_legal: assert property (@(posedge clk_i)
        (DEPTH >= HPDCACHE_REQ_BUF_MIN_DEPTH) && (DEPTH <= HPDCACHE_REQ_BUF_MAX_DEPTH));

    a_pend_occupied: assert property (@(posedge clk_i) disable iff (rst_i)
        pend_vld_q |-> pend_occupied);

    a_pop_has_second_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> (head.snd_vld || (pend_vld_q && (pend_idx_q == rd_ptr_q))));

endmodule

// File: tb/tb_hpdcache_core_req_buf.sv
// Bench for hpdcache_core_req_buf: DEPTH=2 and DEPTH=3 instances, one selected at a time,
// checked every cycle against a queue model plus directed literal expectations.
module tb_hpdcache_core_req_buf;
    import hpdcache_core_req_buf_pkg::*;

    typedef logic [15:0] req_t;
    typedef logic [15:0] tag_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          core_valid;
    req_t          core_req;
    logic          core_abort;
    tag_t          core_tag;
    hpdcache_pma_t core_pma;
    logic          xr;

    always #5 clk = ~clk;

    logic          cv0, cv1, xr0, xr1;
    logic          ready_o [2];
    logic          valid_o [2];
    req_t          xreq_o  [2];
    logic          abort_o [2];
    tag_t          tag_o   [2];
    hpdcache_pma_t pma_o   [2];

    assign cv0 = core_valid & ~sel;
    assign cv1 = core_valid &  sel;
    assign xr0 = xr & ~sel;
    assign xr1 = xr &  sel;

    hpdcache_core_req_buf #(
        .hpdcache_req_t(req_t),
        .hpdcache_tag_t(tag_t),
        .DEPTH(2)
    ) u0 (
        .clk_i(clk), .rst_i(rst),
        .core_req_valid_i(cv0), .core_req_ready_o(ready_o[0]), .core_req_i(core_req),
        .core_req_abort_i(core_abort), .core_req_tag_i(core_tag), .core_req_pma_i(core_pma),
        .xbar_req_valid_o(valid_o[0]), .xbar_req_ready_i(xr0), .xbar_req_o(xreq_o[0]),
        .xbar_req_abort_o(abort_o[0]), .xbar_req_tag_o(tag_o[0]), .xbar_req_pma_o(pma_o[0])
    );

    hpdcache_core_req_buf #(
        .hpdcache_req_t(req_t),
        .hpdcache_tag_t(tag_t),
        .DEPTH(3)
    ) u1 (
        .clk_i(clk), .rst_i(rst),
        .core_req_valid_i(cv1), .core_req_ready_o(ready_o[1]), .core_req_i(core_req),
        .core_req_abort_i(core_abort), .core_req_tag_i(core_tag), .core_req_pma_i(core_pma),
        .xbar_req_valid_o(valid_o[1]), .xbar_req_ready_i(xr1), .xbar_req_o(xreq_o[1]),
        .xbar_req_abort_o(abort_o[1]), .xbar_req_tag_o(tag_o[1]), .xbar_req_pma_o(pma_o[1])
    );

    logic          cur_ready, cur_valid, cur_abort;
    req_t          cur_xreq;
    tag_t          cur_tag;
    hpdcache_pma_t cur_pma;
    logic [31:0]   cur_count;

    assign cur_ready = sel ? ready_o[1] : ready_o[0];
    assign cur_valid = sel ? valid_o[1] : valid_o[0];
    assign cur_xreq  = sel ? xreq_o[1]  : xreq_o[0];
    assign cur_abort = sel ? abort_o[1] : abort_o[0];
    assign cur_tag   = sel ? tag_o[1]   : tag_o[0];
    assign cur_pma   = sel ? pma_o[1]   : pma_o[0];
    assign cur_count = sel ? 32'(u1.count_q) : 32'(u0.count_q);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of requests; each one's second-cycle fields are
    // whatever the core drives in the cycle after its handshake.
    typedef struct {
        req_t       req;
        int         seq;
        logic       filled;
        logic       abort;
        tag_t       tag;
        logic [1:0] pma;
    } mrec_t;

    mrec_t      mq[$];
    logic       m_pend = 1'b0;
    int         m_pend_seq = 0;
    int         m_seq = 0;
    logic       m_abort = 1'b0;
    tag_t       m_tag = '0;
    logic [1:0] m_pma = '0;
    bit         model_ok = 1'b0;
    logic       m_push, m_pop;

    function automatic int mdepth();
        return sel ? 3 : 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pend   = 1'b0;
            m_abort  = 1'b0;
            m_tag    = '0;
            m_pma    = '0;
            model_ok = 1'b1;
        end else begin
            m_push = core_valid && (mq.size() < mdepth());
            m_pop  = (mq.size() > 0) && xr;
            if (m_pop) begin
                if (mq[0].filled) begin
                    m_abort = mq[0].abort;
                    m_tag   = mq[0].tag;
                    m_pma   = mq[0].pma;
                end else begin
                    m_abort = core_abort;
                    m_tag   = core_tag;
                    m_pma   = core_pma;
                end
                void'(mq.pop_front());
            end
            if (m_pend) begin
                foreach (mq[i]) begin
                    if (mq[i].seq == m_pend_seq) begin
                        mq[i].filled = 1'b1;
                        mq[i].abort  = core_abort;
                        mq[i].tag    = core_tag;
                        mq[i].pma    = core_pma;
                    end
                end
            end
            if (m_push) begin
                mq.push_back('{req: core_req, seq: m_seq, filled: 1'b0,
                               abort: 1'b0, tag: '0, pma: '0});
                m_pend     = 1'b1;
                m_pend_seq = m_seq;
                m_seq++;
            end else begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cmp_ready", cur_ready, (mq.size() < mdepth()));
            check("cmp_valid", cur_valid, (mq.size() > 0));
            if (mq.size() > 0) check("cmp_req", cur_xreq, mq[0].req);
            check("cmp_abort", cur_abort, m_abort);
            check("cmp_tag", cur_tag, m_tag);
            check("cmp_pma", cur_pma, m_pma);
            check("cmp_count", cur_count, mq.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        sel        = s;
        rst        = 1'b1;
        core_valid = 1'b0;
        xr         = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    int pushed;
    int cyc;

    initial begin
        sel = 1'b0; rst = 1'b1; core_valid = 1'b0; core_req = '0;
        core_abort = 1'b0; core_tag = '0; core_pma = '0; xr = 1'b0;
        tick();
        do_reset(1'b0);

        // Single request with bypass of the second-cycle fields
        core_valid = 1'b1; core_req = 16'h00A1; xr = 1'b1;
        check("t1_ready_c0", cur_ready, 1'b1);
        check("t1_valid_c0", cur_valid, 1'b0);
        tick();
        core_valid = 1'b0; core_tag = 16'h1234; core_abort = 1'b0; core_pma = 2'b01;
        check("t1_valid_c1", cur_valid, 1'b1);
        check("t1_req_c1", cur_xreq, 16'h00A1);
        tick();
        core_tag = 16'hFFFF; core_pma = 2'b00;
        check("t1_tag_c2", cur_tag, 16'h1234);
        check("t1_abort_c2", cur_abort, 1'b0);
        check("t1_pma_c2", cur_pma, 2'b01);
        check("t1_valid_c2", cur_valid, 1'b0);
        xr = 1'b0;
        tick(); tick();

        // Streaming at full rate through DEPTH=2
        xr = 1'b1;
        for (int c = 0; c < 10; c++) begin
            core_valid = (c < 8);
            core_req   = 16'h0100 + 16'(c);
            core_tag   = (c >= 1) ? 16'h2000 + 16'(c - 1) : 16'h0000;
            core_pma   = 2'(c);
            check("t2_ready", cur_ready, 1'b1);
            if (c >= 1 && c <= 8) begin
                check("t2_valid", cur_valid, 1'b1);
                check("t2_req", cur_xreq, 16'h0100 + 16'(c - 1));
            end
            if (c >= 2) check("t2_tag", cur_tag, 16'h2000 + 16'(c - 2));
            tick();
        end
        core_valid = 1'b0; xr = 1'b0;
        tick();

        // Backpressure: fill, refuse a third, then drain
        core_valid = 1'b1; core_req = 16'h0A0A;
        tick();
        core_req = 16'h0B0B; core_tag = 16'h003A; core_pma = 2'b10;
        tick();
        core_req = 16'h0C0C; core_tag = 16'h003B; core_pma = 2'b11;
        check("t3_ready_c2", cur_ready, 1'b0);
        tick();
        core_tag = 16'h7777; core_pma = 2'b00;
        check("t3_ready_c3", cur_ready, 1'b0);
        tick();
        check("t3_ready_c4", cur_ready, 1'b0);
        tick();
        xr = 1'b1;
        check("t3_ready_c5", cur_ready, 1'b0);
        check("t3_req_c5", cur_xreq, 16'h0A0A);
        tick();
        core_valid = 1'b0;
        check("t3_ready_c6", cur_ready, 1'b1);
        check("t3_tag_c6", cur_tag, 16'h003A);
        check("t3_pma_c6", cur_pma, 2'b10);
        check("t3_req_c6", cur_xreq, 16'h0B0B);
        tick();
        xr = 1'b0;
        check("t3_tag_c7", cur_tag, 16'h003B);
        check("t3_pma_c7", cur_pma, 2'b11);
        check("t3_valid_c7", cur_valid, 1'b0);
        tick();

        // Aborted request is still forwarded after a 3-cycle stall
        core_valid = 1'b1; core_req = 16'h0DDD;
        tick();
        core_valid = 1'b0; core_abort = 1'b1; core_tag = 16'h004D; core_pma = 2'b00;
        check("t4_valid_c1", cur_valid, 1'b1);
        tick();
        core_abort = 1'b0; core_tag = 16'h0000;
        tick(); tick();
        xr = 1'b1;
        check("t4_req_c4", cur_xreq, 16'h0DDD);
        tick();
        xr = 1'b0;
        check("t4_abort_c5", cur_abort, 1'b1);
        check("t4_tag_c5", cur_tag, 16'h004D);
        tick();

        // Wrap-around on DEPTH=3 with pseudo-random crossbar stalls
        do_reset(1'b1);
        pushed = 0;
        cyc    = 0;
        while ((pushed < 10 || mq.size() > 0) && cyc < 200) begin
            core_valid = (pushed < 10);
            core_req   = 16'h0500 + 16'(pushed);
            core_tag   = 16'h5000 + 16'(cyc);
            core_pma   = 2'(cyc);
            core_abort = (cyc % 3 == 0);
            xr         = ($urandom % 3) != 0;
            if (core_valid && mq.size() < 3) pushed++;
            tick();
            cyc++;
        end
        core_valid = 1'b0; core_abort = 1'b0; xr = 1'b0;
        check("t5_bound", (cyc < 200), 1'b1);
        check("t5_pushed", pushed, 10);
        tick();
        check("t5_drained", cur_valid, 1'b0);

        // Reset with two entries held and a second-cycle capture pending
        do_reset(1'b0);
        core_valid = 1'b1; core_req = 16'h0E00; xr = 1'b1;
        tick();
        core_valid = 1'b0; core_tag = 16'h6A6A; core_pma = 2'b11;
        tick();
        xr = 1'b0;
        check("t6_tag_pre", cur_tag, 16'h6A6A);
        core_valid = 1'b1; core_req = 16'h0E01;
        tick();
        core_req = 16'h0E02; core_tag = 16'h6001;
        tick();
        core_valid = 1'b0; core_tag = 16'h6002; rst = 1'b1;
        check("t6_ready_full", cur_ready, 1'b0);
        check("t6_valid_full", cur_valid, 1'b1);
        tick();
        rst = 1'b0; xr = 1'b1;
        check("t6_valid_rst", cur_valid, 1'b0);
        check("t6_ready_rst", cur_ready, 1'b1);
        check("t6_tag_rst", cur_tag, 16'h0000);
        check("t6_pma_rst", cur_pma, 2'b00);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_no_stale", cur_valid, 1'b0);
        end
        xr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpdcache_core_req_buf.md
Name: hpdcache_core_req_buf

Overview:
- Per-requester request buffer placed directly upstream of one requester port of the HPDcache bank crossbar.
- Decouples the core's ready from the bank's combinational ready path, breaking the long ready chain through the arbiter.
- Preserves the two-cycle request protocol: the request comes in cycle 1; abort, tag and PMA come in cycle 2.
  - Core side: cycle 2 follows the core-side handshake.
  - Crossbar side: cycle 2 follows the crossbar-side handshake.
- One instance per requester, between the core and the crossbar.

Parameters:
- hpdcache_req_t, type, logic: request payload type (shared package).
- hpdcache_tag_t, type, logic: physical tag type.
- DEPTH, 2, number of buffered entries. Legal range is 2..8; need not be a power of 2.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- core_req_valid_i  in  1  core request valid (cycle 1).
- core_req_ready_o  out  1  buffer can accept a request.
- core_req_i  in  $bits(hpdcache_req_t)  request payload.
- core_req_abort_i  in  1  abort, sampled the cycle after a core handshake.
- core_req_tag_i  in  $bits(hpdcache_tag_t)  tag, sampled the cycle after a core handshake.
- core_req_pma_i  in  $bits(hpdcache_pma_t)  PMA, sampled the cycle after a core handshake.
- xbar_req_valid_o  out  1  head entry valid toward the crossbar.
- xbar_req_ready_i  in  1  crossbar accepted the head.
- xbar_req_o  out  $bits(hpdcache_req_t)  head payload.
- xbar_req_abort_o  out  1  abort for the request handshaken last cycle.
- xbar_req_tag_o  out  $bits(hpdcache_tag_t)  tag for the request handshaken last cycle.
- xbar_req_pma_o  out  $bits(hpdcache_pma_t)  PMA for the request handshaken last cycle.

Behaviour:
- Entry contents: req, abort, tag, pma, and a snd_vld flag (second-cycle fields written).
- Circular FIFO with wr_ptr, rd_ptr and count.
  - Pointers wrap from DEPTH-1 to 0.
  - count width is $clog2(DEPTH+1).
- Push: core_req_valid_i & core_req_ready_o. The entry at wr_ptr is written with req and snd_vld=0.
  - pend_vld<=1 and pend_idx<=wr_ptr.
- Second-cycle capture: when pend_vld is high, entry[pend_idx] takes abort/tag/pma from the core inputs and snd_vld=1.
  - pend_vld then clears unless a new push occurs in the same cycle.
- Ready and valid are registered-state only:
  - core_req_ready_o = (count != DEPTH).
  - xbar_req_valid_o = (count != 0).
  - Neither depends combinationally on xbar_req_ready_i.
- No flow-through: a request is visible to the crossbar at the earliest one cycle after its core handshake.
- Pop: xbar_req_valid_o & xbar_req_ready_i, at cycle M. Capture out_{abort,tag,pma} as follows:
  - If entry[rd_ptr].snd_vld=1, take the stored fields.
  - Otherwise (head pushed at M-1, so pend_idx==rd_ptr), take the live core inputs (bypass).
- The out_* registers drive xbar_req_{abort,tag,pma}_o at M+1. They hold their value until the next pop.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - DEPTH=2 sustains one request per cycle.
- Full: no push. A pop in the same cycle does not re-enable ready until the next cycle.
- Empty: xbar_req_valid_o=0, and xbar_req_o holds stale data (don't care).
- Abort is forwarded faithfully. Aborted entries are not dropped, because the bank owns abort handling.
- Reset, including mid-operation:
  - count=0, pointers=0, pend_vld=0, all snd_vld=0.
  - out_abort=0, out_tag='0, out_pma='0.
  - Hence core_req_ready_o=1 and xbar_req_valid_o=0 one cycle after reset.
  - Buffered entries and any pending second-cycle capture are discarded.
- Assertions:
  - pend_vld implies entry[pend_idx] is occupied.
  - No pop of an entry with snd_vld=0 unless pend_idx==rd_ptr.

Decomposition:
- hpdcache_pkg already supplies hpdcache_pma_t. Add an hpdcache_req_buf_entry_t struct (req, abort, tag, pma, snd_vld) there only if reused elsewhere; otherwise keep it local.
- Storage uses the existing hpdcache_regbank-style flop array inline.
- No separate sub-module is needed; an optional hpdcache_req_buf_ptr counter helper is acceptable.

Test Plan:
- Single request: core push A at cycle 0 with tag 0x1234 at cycle 1, xbar ready=1 → xbar_req_valid_o=1 at cycle 1 (handshake via bypass); xbar_req_tag_o=0x1234 and abort=0 at cycle 2.
- Back-to-back streaming, DEPTH=2: push 8 requests on consecutive cycles with xbar ready=1 → 8 pops on cycles 1..8, core_req_ready_o never drops, and each tag appears one cycle after its pop, in order.
- Backpressure: xbar ready=0, push A and B → core_req_ready_o=0 from cycle 2. Release ready at cycle 5 → A pops at 5 and B at 6; stored tags appear at 6 and 7, and ready returns at 6.
- Abort: push A with abort=1 at the second cycle while xbar is stalled 3 cycles → A is still forwarded, and xbar_req_abort_o=1 the cycle after its pop.
- Wrap-around, DEPTH=3: 10 pushes with random xbar stalls → output order, tag/pma pairing and count all match the reference model.
- Reset with 2 entries held and one capture pending: assert rst_i one cycle → xbar_req_valid_o=0 and core_req_ready_o=1 next cycle; no stale entry is ever emitted.
